// File: rtl/d_74ls148_pkg.sv
// Shared types, widths and helpers for the 74LS148-style interrupt encoder.
package d_74ls148_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    // Code output value when nothing is being presented (active-low "no index").
    localparam logic [CODE_W-1:0] A_IDLE = 3'b111;

    typedef enum logic {IDLE, HOLD} enc_state_t;

    // One-hot mask for a request index, used to clear the acknowledged bit.
    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/d_74ls148_if.sv
// Request/code bus between request sources, the encoder and its consumer.
// Pin semantics follow the 74LS148: EI, I, A, GS and EO are active-low.
interface d_74ls148_if;
    import d_74ls148_pkg::*;

    logic              EI;
    logic [N_REQ-1:0]  I;
    logic              ack;
    logic [CODE_W-1:0] A;
    logic              GS;
    logic              EO;

    // Controller side: drives requests/enable/ack and observes the code.
    modport master (output EI, I, ack, input A, GS, EO);
    // Encoder side.
    modport slave  (input EI, I, ack, output A, GS, EO);
endinterface

// File: rtl/d_74ls148_prio.sv
// Combinational 8-to-3 priority encoder; the highest set index wins.
module d_74ls148_prio
    import d_74ls148_pkg::*;
(
    input  logic [N_REQ-1:0]  req,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [N_REQ-1:0] win;

    // A bit wins only when no higher-indexed bit is set.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_win
        if (gi == N_REQ - 1) begin : g_top
            assign win[gi] = req[gi];
        end else begin : g_rest
            assign win[gi] = req[gi] & ~(|req[N_REQ-1:gi+1]);
        end
    end

    // At most one win bit is set, so OR-ing the indices yields that index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                idx = idx | CODE_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/d_74ls148_irq_encoder.sv
// Registered priority encoder with sticky pending requests and a code that
// is held frozen until the consumer acknowledges it.
module d_74ls148_irq_encoder
    import d_74ls148_pkg::*;
#(
    parameter bit STICKY = 1'b1
)(
    input  logic          clk,
    input  logic          rst,
    d_74ls148_if.slave    bus
);

    enc_state_t        state_reg, state_next;
    logic [N_REQ-1:0]  pend_reg, pend_next;
    logic [N_REQ-1:0]  clr;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CODE_W-1:0] a_reg, a_next;
    logic              gs_reg, gs_next;
    logic              eo_reg, eo_next;
    logic [CODE_W-1:0] prio_idx;
    logic              prio_any;

    // Pending update: new requests OR'd in after the ack clear, so a bit
    // that is both requested and acknowledged in one cycle stays pending.
    always_comb begin
        clr = '0;
        if (state_reg == HOLD && bus.ack) begin
            clr = onehot(code_reg);
        end
        if (bus.EI) begin
            pend_next = pend_reg;
        end else if (STICKY) begin
            pend_next = (pend_reg & ~clr) | ~bus.I;
        end else begin
            pend_next = ~bus.I;
        end
    end

    d_74ls148_prio u_prio (
        .req (pend_next),
        .idx (prio_idx),
        .any (prio_any)
    );

    // FSM next state and output values; outputs are derived from the
    // next state so they line up with the state register.
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        if (bus.EI) begin
            state_next = IDLE;
        end else if (state_reg == IDLE) begin
            if (prio_any) begin
                state_next = HOLD;
                code_next  = prio_idx;
            end
        end else if (bus.ack) begin
            state_next = IDLE;
        end

        a_next  = A_IDLE;
        gs_next = 1'b1;
        eo_next = 1'b1;
        if (state_next == HOLD) begin
            a_next  = ~code_next;
            gs_next = 1'b0;
        end else if (!bus.EI && !prio_any) begin
            eo_next = 1'b0;
        end
    end

    // State, pending and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            code_reg  <= '0;
            a_reg     <= A_IDLE;
            gs_reg    <= 1'b1;
            eo_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            code_reg  <= code_next;
            a_reg     <= a_next;
            gs_reg    <= gs_next;
            eo_reg    <= eo_next;
        end
    end

    assign bus.A  = a_reg;
    assign bus.GS = gs_reg;
    assign bus.EO = eo_reg;

endmodule

// File: tb/tb_d_74ls148_irq_encoder.sv
// Directed bench for the interrupt encoder: each step drives inputs, queues
// the expected {A, GS, EO} and compares it after the following clock edge.
module tb_d_74ls148_irq_encoder;

    typedef struct {
        logic [4:0] val;   // {A, GS, EO}
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    d_74ls148_if bus ();

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    d_74ls148_irq_encoder #(.STICKY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic step(input logic r, input logic ei, input logic [7:0] i,
                        input logic ak, input logic [2:0] ea, input logic egs,
                        input logic eeo, input string tag);
        exp_t e;
        exp_t got;
        logic [4:0] obs;
        rst     = r;
        bus.EI  = ei;
        bus.I   = i;
        bus.ack = ak;
        e.val = {ea, egs, eeo};
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        obs = {bus.A, bus.GS, bus.EO};
        total++;
        if (sb.size() == 0) begin
            $error("FAIL %s: observed %b with no queued expectation", tag, obs);
        end else begin
            got = sb.pop_front();
            assert (obs === got.val) passed++;
            else $error("FAIL %s: observed A/GS/EO=%b expected %b", got.tag, obs, got.val);
        end
        $display("step %-14s rst=%b EI=%b I=%h ack=%b -> A=%b GS=%b EO=%b",
                 tag, r, ei, i, ak, bus.A, bus.GS, bus.EO);
    endtask

    initial begin
        rst = 1'b1; bus.EI = 1'b1; bus.I = 8'hFF; bus.ack = 1'b0;

        // Reset and idle
        step(1, 0, 8'hFF, 0, 3'b111, 1, 1, "reset0");
        step(1, 0, 8'hFF, 0, 3'b111, 1, 1, "reset1");
        step(0, 0, 8'hFF, 0, 3'b111, 1, 0, "idle_eo");

        // Priority order: bits 5 and 2 in one pulse
        step(0, 0, 8'hDB, 0, 3'b010, 0, 1, "prio5");
        step(0, 0, 8'hFF, 0, 3'b010, 0, 1, "hold5a");
        step(0, 0, 8'hFF, 0, 3'b010, 0, 1, "hold5b");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 1, "ack5_gap");
        step(0, 0, 8'hFF, 0, 3'b101, 0, 1, "prio2");

        // Freeze: higher request while presenting 2
        step(0, 0, 8'h7F, 0, 3'b101, 0, 1, "freeze_a");
        step(0, 0, 8'hFF, 0, 3'b101, 0, 1, "freeze_b");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 1, "ack2_gap");
        step(0, 0, 8'hFF, 0, 3'b000, 0, 1, "prio7");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 0, "ack7_empty");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 0, "ack_idle_ign");

        // Simultaneous set and clear on bit 4
        step(0, 0, 8'hEF, 0, 3'b011, 0, 1, "prio4");
        step(0, 0, 8'hEF, 1, 3'b111, 1, 1, "setclr_gap");
        step(0, 0, 8'hEF, 0, 3'b011, 0, 1, "prio4_again");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 0, "ack4_empty");

        // Enable control during HOLD of code 6
        step(0, 0, 8'hBF, 0, 3'b001, 0, 1, "prio6");
        step(0, 0, 8'hFF, 0, 3'b001, 0, 1, "hold6");
        step(0, 1, 8'hFF, 0, 3'b111, 1, 1, "ei_off_a");
        step(0, 1, 8'hFF, 1, 3'b111, 1, 1, "ei_off_b");
        step(0, 0, 8'hFF, 0, 3'b001, 0, 1, "ei_on_prio6");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 0, "ack6_empty");

        // Requests are not sampled while disabled
        step(0, 1, 8'hFE, 0, 3'b111, 1, 1, "ei_nosample");
        step(0, 0, 8'hFF, 0, 3'b111, 1, 0, "ei_nosample_chk");

        // Reset in the middle of HOLD with bits 3 and 1 pending
        step(0, 0, 8'hF5, 0, 3'b100, 0, 1, "prio3");
        step(1, 0, 8'hFF, 0, 3'b111, 1, 1, "mid_reset");
        step(0, 0, 8'hFF, 0, 3'b111, 1, 0, "post_reset_a");
        step(0, 0, 8'hFF, 0, 3'b111, 1, 0, "post_reset_b");

        // Lowest-priority request alone
        step(0, 0, 8'hFE, 0, 3'b111, 0, 1, "prio0");
        step(0, 0, 8'hFF, 1, 3'b111, 1, 0, "ack0_empty");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
